button_event_decoder: RTL and testbench



---
 rtl/button_event_decoder_pkg.sv | 14 +
 rtl/button_event_decoder_if.sv | 24 ++
 rtl/button_event_decoder_evt_tick_counter.sv | 27 ++
 rtl/button_event_decoder.sv | 126 ++++++++++++
 tb/tb_button_event_decoder.sv | 120 ++++++++++++
 5 files changed

// File: rtl/button_event_decoder_pkg.sv
// Shared types for the button event decoder.
// State encoding and default counter width.
package button_event_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_LONG    = 2'd3
  } state_t;

endpackage

// File: rtl/button_event_decoder_if.sv
// Control/flag bundle between the decoder FSM and a tick counter.
// Master drives clear/enable/term, slave reports terminal count.
interface evt_cnt_if #(
  parameter int W = 8
);
  logic         clear;
  logic         enable;
  logic [W-1:0] term;
  logic         tc;

  modport master (
    output clear,
    output enable,
    output term,
    input  tc
  );

  modport slave (
    input  clear,
    input  enable,
    input  term,
    output tc
  );
endinterface

// File: rtl/button_event_decoder_evt_tick_counter.sv
// Hold/repeat tick counter with clear, enable and terminal flag.
// clear together with enable loads 1 (first counted sample).
module evt_tick_counter
  import button_event_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  evt_cnt_if.slave   c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (c.clear) begin
      cnt <= c.enable ? CNT_W'(1) : '0;
    end else if (c.enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign c.tc = (cnt == c.term);

endmodule

// File: rtl/button_event_decoder.sv
// Decodes a held button level into press/long/repeat event pulses.
// Auto-repeat is built only with BUTTON_EVENT_REPEAT_EN defined.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_CNT   = 8,
  parameter int REPEAT_CNT = 4,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic IPTCLK,
  input  logic IPTRST,
  input  logic IPTBTN,
  output logic OUTPRESS,
  output logic OUTLONG,
  output logic OUTREPEAT,
  output logic OUTHOLD
);

  if (LONG_CNT < 2 || LONG_CNT > (1 << CNT_W) - 1) begin : g_bad_long
    $error("LONG_CNT out of range");
  end
  if (REPEAT_CNT < 2 || REPEAT_CNT > (1 << CNT_W) - 1) begin : g_bad_rep
    $error("REPEAT_CNT out of range");
  end

  state_t state;

  evt_cnt_if #(.W(CNT_W)) h ();

  evt_tick_counter #(.CNT_W(CNT_W)) u_hcnt (
    .clk (IPTCLK),
    .rst (IPTRST),
    .c   (h.slave)
  );

  always_comb begin
    h.clear  = 1'b1;
    h.enable = 1'b0;
    h.term   = CNT_W'(LONG_CNT - 1);
    unique case (state)
      ST_IDLE:    h.enable = IPTBTN;
      ST_PRESSED: begin
        h.clear  = 1'b0;
        h.enable = IPTBTN & ~h.tc;
      end
      default:    h.clear = 1'b1;
    endcase
  end

`ifdef BUTTON_EVENT_REPEAT_EN
  evt_cnt_if #(.W(CNT_W)) r ();

  evt_tick_counter #(.CNT_W(CNT_W)) u_rcnt (
    .clk (IPTCLK),
    .rst (IPTRST),
    .c   (r.slave)
  );

  // Outside a held LONG the repeat count sits at 0, ready for entry.
  always_comb begin
    r.clear  = 1'b1;
    r.enable = 1'b0;
    r.term   = CNT_W'(REPEAT_CNT - 1);
    if (state == ST_LONG && IPTBTN) begin
      r.clear  = r.tc;
      r.enable = ~r.tc;
    end
  end
`else
  assign OUTREPEAT = 1'b0;
`endif

  always_ff @(posedge IPTCLK) begin
    if (IPTRST) begin
      state    <= ST_ARM;
      OUTPRESS <= 1'b0;
      OUTLONG  <= 1'b0;
      OUTHOLD  <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      OUTREPEAT <= 1'b0;
`endif
    end else begin
      OUTPRESS <= 1'b0;
      OUTLONG  <= 1'b0;
      OUTHOLD  <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
      OUTREPEAT <= 1'b0;
`endif
      unique case (state)
        ST_ARM: begin
          if (!IPTBTN) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (IPTBTN) begin
            state   <= ST_PRESSED;
            OUTHOLD <= 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!IPTBTN) begin
            state    <= ST_IDLE;
            OUTPRESS <= 1'b1;
          end else begin
            OUTHOLD <= 1'b1;
            if (h.tc) begin
              state   <= ST_LONG;
              OUTLONG <= 1'b1;
            end
          end
        end
        ST_LONG: begin
          if (!IPTBTN) begin
            state <= ST_IDLE;
          end else begin
            OUTHOLD <= 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
            OUTREPEAT <= r.tc;
`endif
          end
        end
        default: state <= ST_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed vector bench for button_event_decoder (LONG_CNT=8, REPEAT_CNT=4).
// Outputs are checked as {press, long, repeat, hold} one step after each edge.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic o_press, o_long, o_rep, o_hold;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_CNT   (8),
    .REPEAT_CNT (4),
    .CNT_W      (8)
  ) dut (
    .IPTCLK    (clk),
    .IPTRST    (rst),
    .IPTBTN    (btn),
    .OUTPRESS  (o_press),
    .OUTLONG   (o_long),
    .OUTREPEAT (o_rep),
    .OUTHOLD   (o_hold)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  vec_t v[$];

  task automatic add(input string nm, input logic r, input logic b,
                     input logic [3:0] e, input int n = 1);
    for (int i = 0; i < n; i++) begin
      vec_t t;
      t.name = nm;
      t.rst  = r;
      t.btn  = b;
      t.exp  = e;
      v.push_back(t);
    end
  endtask

  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [3:0] exp);
    logic [3:0] got;
    got = {o_press, o_long, o_rep, o_hold};
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got plrh=%b expected %b", nm, idx, got, exp);
    end
  endtask

  initial begin
    // held through reset, then ARM must swallow the release
    add("rst_held",  1, 1, 4'b0000, 2);
    add("arm_held",  0, 1, 4'b0000, 20);
    add("arm_rel",   0, 0, 4'b0000, 3);
    add("p3_hold",   0, 1, 4'b0001, 3);
    add("p3_press",  0, 0, 4'b1000);
    add("p3_idle",   0, 0, 4'b0000, 2);
    add("p7_hold",   0, 1, 4'b0001, 7);
    add("p7_press",  0, 0, 4'b1000);
    add("p7_idle",   0, 0, 4'b0000, 2);
    add("l8_hold",   0, 1, 4'b0001, 7);
    add("l8_long",   0, 1, 4'b0101);
    add("l8_rel",    0, 0, 4'b0000, 3);
    add("b2b_h1",    0, 1, 4'b0001);
    add("b2b_p1",    0, 0, 4'b1000);
    add("b2b_h2",    0, 1, 4'b0001);
    add("b2b_p2",    0, 0, 4'b1000);
    add("b2b_idle",  0, 0, 4'b0000, 2);
    add("mr_hold",   0, 1, 4'b0001, 4);
    add("mr_rst",    1, 1, 4'b0000);
    add("mr_arm",    0, 1, 4'b0000, 2);
    add("mr_rel",    0, 0, 4'b0000, 2);
    add("mr_p2h",    0, 1, 4'b0001, 2);
    add("mr_p2p",    0, 0, 4'b1000);
    add("mr_idle",   0, 0, 4'b0000, 2);

    foreach (v[i]) begin
      step(v[i].rst, v[i].btn);
      check(v[i].name, i, v[i].exp);
    end

    // long hold of 20 samples: LONG after 8, repeats after 12, 16, 20
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] e;
      e = 4'b0001;
      if (k == 8) e = 4'b0101;
`ifdef BUTTON_EVENT_REPEAT_EN
      if (k == 12 || k == 16 || k == 20) e = 4'b0011;
`endif
      step(0, 1);
      check("rep_hold", k, e);
    end
    step(0, 0);
    check("rep_rel", 0, 4'b0000);
    step(0, 0);
    check("rep_idle", 0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
